// File: rtl/mm_pkg.sv
// Shared types and encodings for the 2x2 matrix-multiply host sequencer.
package mm_pkg;

  localparam int unsigned N_OPERANDS = 8;
  localparam int unsigned N_RESULTS  = 4;
  localparam int unsigned CNT_W      = $clog2(N_OPERANDS);
  localparam int unsigned IDX_W      = $clog2(N_RESULTS);

  typedef enum logic [2:0] {
    RECV      = 3'd0,
    WAIT_DONE = 3'd1,
    FETCH     = 3'd2,
    HOLD      = 3'd3,
    GAP       = 3'd4
  } seq_state_t;

  // Element index as the controller decodes it (row, column).
  typedef enum logic [IDX_W-1:0] {
    IDX_X00 = 2'd0,
    IDX_X01 = 2'd1,
    IDX_X10 = 2'd2,
    IDX_X11 = 2'd3
  } elem_idx_t;

  // Operand byte n is A[n] for n < 4, B[n-4] otherwise.
  function automatic logic elem_is_b(input logic [CNT_W-1:0] n);
    return n[CNT_W-1];
  endfunction

  function automatic logic [IDX_W-1:0] elem_index(input logic [CNT_W-1:0] n);
    return n[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/mm_host_sequencer.sv
// Host-side sequencer: streams 8 operand bytes into the matrix controller as
// load strobes, waits for done, then drains 4 result bytes onto a master stream.
module mm_host_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              load_en,
  output logic              load_sel_ab,
  output logic [1:0]        load_index,
  output logic [DATA_W-1:0] load_data,
  output logic              out_en,
  output logic [1:0]        out_sel,
  input  logic [DATA_W-1:0] out_data,
  input  logic              core_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_next;

  logic              s_ready_d, load_en_d, load_sel_ab_d;
  logic [1:0]        load_index_d, out_sel_d;
  logic [DATA_W-1:0] load_data_d, m_data_d;
  logic              m_valid_d, m_last_d, out_en_d, busy_d, timeout_err_d;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    tmo_next      = tmo_q + TMO_W'(1);
    s_ready_d     = s_ready;
    load_en_d     = 1'b0;
    load_sel_ab_d = load_sel_ab;
    load_index_d  = load_index;
    load_data_d   = load_data;
    m_valid_d     = m_valid;
    m_last_d      = m_last;
    m_data_d      = m_data;
    out_en_d      = out_en;
    out_sel_d     = out_sel;
    timeout_err_d = timeout_err;

    case (state_q)
      RECV: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready) begin
          load_en_d     = 1'b1;
          load_sel_ab_d = elem_is_b(cnt_q);
          load_index_d  = elem_index(cnt_q);
          load_data_d   = s_data;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_OPERANDS - 1)) begin
            s_ready_d = 1'b0;
            tmo_d     = '0;
            state_d   = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_next;
        if (core_done) begin
          out_en_d  = 1'b1;
          out_sel_d = IDX_X00;
          idx_d     = IDX_X00;
          state_d   = FETCH;
        end else if (tmo_next == TMO_W'(DONE_TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
        end
      end
      FETCH: begin
        m_data_d  = out_data;
        m_valid_d = 1'b1;
        m_last_d  = (idx_q == IDX_X11);
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (idx_q == IDX_X11) begin
            m_last_d = 1'b0;
            out_en_d = 1'b0;
            state_d  = GAP;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            out_sel_d = idx_q + IDX_W'(1);
            state_d   = FETCH;
          end
        end
      end
      GAP: begin
        // One idle cycle with out_en low lets the controller return to idle.
        out_en_d  = 1'b0;
        s_ready_d = 1'b1;
        cnt_d     = '0;
        idx_d     = '0;
        state_d   = RECV;
      end
      default: state_d = RECV;
    endcase

    busy_d = (state_d != RECV);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RECV;
      cnt_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      s_ready     <= 1'b1;
      load_en     <= 1'b0;
      load_sel_ab <= 1'b0;
      load_index  <= '0;
      load_data   <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      out_en      <= 1'b0;
      out_sel     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      s_ready     <= s_ready_d;
      load_en     <= load_en_d;
      load_sel_ab <= load_sel_ab_d;
      load_index  <= load_index_d;
      load_data   <= load_data_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
      m_data      <= m_data_d;
      out_en      <= out_en_d;
      out_sel     <= out_sel_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Self-checking bench for mm_host_sequencer with a behavioural 2x2 controller model.
module tb_mm_host_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO    = 16;

  typedef logic [0:3][DATA_W-1:0] mat_t;

  typedef struct {
    mat_t a;
    mat_t b;
    mat_t c;
    int   bub;
    int   stall;
    int   dly;
    bit   glitch;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              load_en;
  logic              load_sel_ab;
  logic [1:0]        load_index;
  logic [DATA_W-1:0] load_data;
  logic              out_en;
  logic [1:0]        out_sel;
  logic [DATA_W-1:0] out_data;
  logic              core_done = 1'b0;
  logic              busy;
  logic              timeout_err;

  mm_host_sequencer #(.DATA_W(DATA_W), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .load_en(load_en), .load_sel_ab(load_sel_ab), .load_index(load_index),
    .load_data(load_data), .out_en(out_en), .out_sel(out_sel),
    .out_data(out_data), .core_done(core_done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model: element memories written by load strobes, product on read.
  logic [DATA_W-1:0] ca [4];
  logic [DATA_W-1:0] cb [4];
  always @(posedge clk) begin
    if (load_en) begin
      if (load_sel_ab) cb[load_index] <= load_data;
      else             ca[load_index] <= load_data;
    end
  end

  always_comb begin
    int i;
    int j;
    i = int'(out_sel[1]);
    j = int'(out_sel[0]);
    out_data = '0;
    if (out_en)
      out_data = DATA_W'(int'(ca[2*i]) * int'(cb[j]) + int'(ca[2*i+1]) * int'(cb[2+j]));
  end

  // Reference: C = A x B on 2x2 row-major matrices, truncated to DATA_W.
  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t c;
    int   acc;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++) acc += int'(a[i*2+k]) * int'(b[k*2+j]);
        c[i*2+j] = DATA_W'(acc);
      end
    return c;
  endfunction

  // Scoreboard state.
  logic [DATA_W-1:0] exp_res [$];
  bit                mon_on    = 1'b0;
  bit                exp_ld_v  = 1'b0;
  int                exp_sel   = 0;
  int                exp_idx   = 0;
  logic [DATA_W-1:0] exp_dat   = '0;
  int                mdl_n     = 0;
  bit                prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int                gap_phase = 0;

  // Cycle monitor: load strobes, result stream, hold stability, gap cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("load_en", int'(load_en), int'(exp_ld_v));
      if (load_en && exp_ld_v) begin
        chk("load_sel_ab", int'(load_sel_ab), exp_sel);
        chk("load_index", int'(load_index), exp_idx);
        chk("load_data", int'(load_data), int'(exp_dat));
      end
      if (prev_hold) begin
        chk("m_valid_held", int'(m_valid), 1);
        chk("m_data_stable", int'(m_data), int'(prev_data));
      end
      if (gap_phase == 1) begin
        chk("gap_out_en", int'(out_en), 0);
        chk("gap_m_valid", int'(m_valid), 0);
        chk("gap_s_ready", int'(s_ready), 0);
        chk("gap_busy", int'(busy), 1);
        gap_phase = 2;
      end else if (gap_phase == 2) begin
        chk("recv_s_ready", int'(s_ready), 1);
        chk("recv_busy", int'(busy), 0);
        gap_phase = 0;
      end
      if (m_valid) begin
        chk("out_en_in_drain", int'(out_en), 1);
        if (m_ready) begin
          chk("result_expected", int'(exp_res.size() > 0), 1);
          if (exp_res.size() > 0) begin
            int r;
            logic [DATA_W-1:0] e;
            r = 4 - exp_res.size();
            e = exp_res.pop_front();
            chk("m_data", int'(m_data), int'(e));
            chk("m_last", int'(m_last), int'(r == 3));
            chk("out_sel", int'(out_sel), r);
            if (r == 3) gap_phase = 1;
          end
        end
      end
    end
    if (rst) begin
      exp_ld_v  = 1'b0;
      mdl_n     = 0;
      prev_hold = 1'b0;
      gap_phase = 0;
      exp_res.delete();
    end else begin
      exp_ld_v = s_valid && s_ready;
      if (exp_ld_v) begin
        exp_sel = int'(mdl_n >= 4);
        exp_idx = mdl_n % 4;
        exp_dat = s_data;
        mdl_n   = (mdl_n + 1) % 8;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // Offer one operand byte, optionally after a one-cycle bubble.
  task automatic send_byte(input logic [DATA_W-1:0] d, input bit bubble);
    bit acc;
    int g;
    if (bubble) begin
      s_valid = 1'b0;
      @(posedge clk); #2;
    end
    s_valid = 1'b1;
    s_data  = d;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #2;
      g++;
    end
    s_valid = 1'b0;
    chk("s_accept", int'(acc), 1);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk); #2;
    core_done = 1'b0;
  endtask

  // core_done while receiving must be ignored.
  task automatic glitch_done();
    pulse_done();
    @(negedge clk);
    chk("glitch_out_en", int'(out_en), 0);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_s_ready", int'(s_ready), 1);
    @(posedge clk); #2;
  endtask

  task automatic send_operands(input mat_t a, input mat_t b, input int bub, input bit glitch);
    bit bb;
    for (int k = 0; k < 8; k++) begin
      bb = (bub == 1) || (bub == 2 && $urandom_range(0, 1) == 1);
      send_byte((k < 4) ? a[k] : b[k-4], bb);
      if (glitch && k == 2) glitch_done();
    end
  endtask

  task automatic run_job(input mat_t a, input mat_t b, input mat_t c,
                         input int bub, input int stall, input int dly, input bit glitch);
    int g;
    m_ready = (stall == 0);
    for (int k = 0; k < 4; k++) exp_res.push_back(c[k]);
    send_operands(a, b, bub, glitch);
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #2;
    end
    pulse_done();
    @(negedge clk);
    chk("fetch_out_en", int'(out_en), 1);
    chk("fetch_out_sel", int'(out_sel), 0);
    chk("fetch_busy", int'(busy), 1);
    for (int r = 0; r < 4; r++) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!m_valid && g < 50);
      chk("m_valid_arrives", int'(m_valid), 1);
      if (!m_valid) break;
      if (stall > 0) begin
        for (int s = 0; s < stall; s++) @(posedge clk);
        #2;
        m_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #2;
      m_ready = (stall == 0);
    end
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    chk("results_drained", exp_res.size(), 0);
  endtask

  vec_t tbl [5];

  task automatic set_vec(input int i, input mat_t a, input mat_t b, input mat_t c,
                         input int bub, input int stall, input int dly, input bit glitch);
    tbl[i].a = a; tbl[i].b = b; tbl[i].c = c;
    tbl[i].bub = bub; tbl[i].stall = stall; tbl[i].dly = dly; tbl[i].glitch = glitch;
  endtask

  initial begin
    mat_t a, b, c;
    int   g;

    set_vec(0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
            {8'd19, 8'd22, 8'd43, 8'd50}, 0, 0, 2, 1'b0);
    set_vec(1, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
            {8'd19, 8'd22, 8'd43, 8'd50}, 1, 0, 0, 1'b1);
    set_vec(2, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
            {8'd19, 8'd22, 8'd43, 8'd50}, 0, 5, 4, 1'b0);
    set_vec(3, {8'd2, 8'd0, 8'd0, 8'd2}, {8'd1, 8'd2, 8'd3, 8'd4},
            {8'd2, 8'd4, 8'd6, 8'd8}, 1, 1, 1, 1'b0);
    set_vec(4, {8'd10, 8'd20, 8'd30, 8'd40}, {8'd5, 8'd6, 8'd7, 8'd8},
            {8'd190, 8'd220, 8'd174, 8'd244}, 0, 2, 6, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_out_en", int'(out_en), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 5; i++)
      run_job(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].bub, tbl[i].stall, tbl[i].dly, tbl[i].glitch);

    // Withheld core_done: abort after TMO cycles in WAIT_DONE, no results.
    send_operands({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 0, 1'b0);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(negedge clk);
      if (k == 1 || k == int'(TMO)) begin
        chk("wait_timeout_err", int'(timeout_err), 0);
        chk("wait_busy", int'(busy), 1);
      end
    end
    @(negedge clk);
    chk("abort_timeout_err", int'(timeout_err), 1);
    chk("abort_gap_s_ready", int'(s_ready), 0);
    chk("abort_m_valid", int'(m_valid), 0);
    @(negedge clk);
    chk("abort_recv_s_ready", int'(s_ready), 1);
    chk("abort_recv_busy", int'(busy), 0);
    @(posedge clk); #2;

    // Next job still runs with the sticky flag set.
    run_job({8'd1, 8'd0, 8'd0, 8'd1}, {8'd9, 8'd8, 8'd7, 8'd6},
            {8'd9, 8'd8, 8'd7, 8'd6}, 0, 0, 3, 1'b0);
    chk("sticky_timeout_err", int'(timeout_err), 1);

    // core_done while idle is ignored.
    glitch_done();

    // Reset while the second result is held.
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_res.push_back(tbl[0].c[k]);
    send_operands(tbl[0].a, tbl[0].b, 0, 1'b0);
    pulse_done();
    g = 0;
    do begin @(negedge clk); g++; end while (!m_valid && g < 50);
    chk("r0_valid", int'(m_valid), 1);
    @(posedge clk); #2;
    m_ready = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!m_valid && g < 50);
    chk("r1_hold_valid", int'(m_valid), 1);
    chk("r1_hold_data", int'(m_data), 22);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_out_en", int'(out_en), 0);
    chk("midrst_load_en", int'(load_en), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    chk("midrst_timeout_err", int'(timeout_err), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #2;

    // Partial operand set is dropped by reset; next job loads from A00.
    for (int k = 0; k < 3; k++) send_byte(8'(8'hA0 + k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    run_job(tbl[3].a, tbl[3].b, tbl[3].c, 0, 0, 2, 1'b0);

    // Randomised jobs against the reference product.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 4; k++) begin
        a[k] = DATA_W'($urandom);
        b[k] = DATA_W'($urandom);
      end
      c = ref_mul(a, b);
      run_job(a, b, c, 2, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
              ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
